axis_multi_ch_segmenter: RTL and testbench

- Next-generation TX framer for the RoCEv2 TX engine.
- Accepts write requests and payload streams on NUM_CH independent channels and arbitrates between them round-robin, one whole transfer at a time.
- Cuts-through each transfer as PMTU-sized segments, with no store-and-forward buffer.
- Emits one segment descriptor per segment (qp, address, length, first/last) before that segment's data, and flags length mismatches between the request and the stream.

---
 rtl/axis_multi_ch_segmenter.sv | 205 ++++++++++++++++++++
 tb/tb_axis_multi_ch_segmenter.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_multi_ch_segmenter.sv
// Multi-channel TX framer: round-robin grants one whole transfer at a time and
// cuts it through as PMTU-sized segments, each preceded by a segment descriptor.
module axis_multi_ch_segmenter #(
    parameter int DATA_WIDTH = 512,
    parameter int NUM_CH     = 4,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int KEEP_W    = DATA_WIDTH / 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_CH-1:0]            s_req_valid,
    output logic [NUM_CH-1:0]            s_req_ready,
    input  logic [NUM_CH*24-1:0]         s_req_loc_qp,
    input  logic [NUM_CH*32-1:0]         s_req_dma_length,
    input  logic [NUM_CH*64-1:0]         s_req_addr_offset,
    input  logic [NUM_CH-1:0]            s_req_is_immediate,
    input  logic [NUM_CH*32-1:0]         s_req_immediate_data,
    input  logic [NUM_CH-1:0]            s_req_tx_type,
    input  logic [NUM_CH*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [NUM_CH*KEEP_W-1:0]     s_axis_tkeep,
    input  logic [NUM_CH-1:0]            s_axis_tvalid,
    output logic [NUM_CH-1:0]            s_axis_tready,
    input  logic [NUM_CH-1:0]            s_axis_tlast,
    output logic                         m_seg_valid,
    input  logic                         m_seg_ready,
    output logic [CH_W-1:0]              m_seg_ch,
    output logic [23:0]                  m_seg_loc_qp,
    output logic [63:0]                  m_seg_addr,
    output logic [12:0]                  m_seg_length,
    output logic                         m_seg_first,
    output logic                         m_seg_last,
    output logic                         m_seg_is_immediate,
    output logic [31:0]                  m_seg_immediate_data,
    output logic                         m_seg_tx_type,
    output logic [DATA_WIDTH-1:0]        m_axis_tdata,
    output logic [KEEP_W-1:0]            m_axis_tkeep,
    output logic                         m_axis_tvalid,
    input  logic                         m_axis_tready,
    output logic                         m_axis_tlast,
    output logic                         m_axis_tuser,
    input  logic [2:0]                   pmtu
);
    localparam int KEEP_SH = $clog2(KEEP_W);

    typedef enum logic [1:0] {IDLE, DESC, DATA, DRAIN} state_t;

    state_t          state, state_nx;
    logic [CH_W-1:0] ptr, grant, arb_ch;
    logic            arb_any;
    logic [12:0]     pm_q;
    logic [31:0]     rem;
    logic [63:0]     cur_addr;
    logic            is_imm_q;
    logic [13:0]     beat_cnt, seg_beats;
    logic            seg_final, in_valid, in_last, early, beat_hs;
    logic            load_first, load_next;
    logic [12:0]     ld_pm, ld_len;
    logic [31:0]     ld_rem;
    logic [63:0]     ld_addr;
    logic            ld_last;

    logic [31:0]     len_sel, immd_sel;
    logic [63:0]     addr_sel;
    logic [23:0]     qp_sel;

    function automatic logic [12:0] pm_bytes(input logic [2:0] p);
        case (p)
            3'd0:    return 13'd256;
            3'd1:    return 13'd512;
            3'd2:    return 13'd1024;
            3'd3:    return 13'd2048;
            default: return 13'd4096;
        endcase
    endfunction

    // Round-robin: scan from ptr+1; the lowest offset found last wins, ptr itself has lowest priority.
    always_comb begin
        arb_any = 1'b0;
        arb_ch  = '0;
        for (int i = NUM_CH; i >= 1; i--) begin
            if (s_req_valid[(int'(ptr) + i) % NUM_CH]) begin
                arb_any = 1'b1;
                arb_ch  = CH_W'((int'(ptr) + i) % NUM_CH);
            end
        end
    end

    assign len_sel  = s_req_dma_length[32*arb_ch +: 32];
    assign addr_sel = s_req_addr_offset[64*arb_ch +: 64];
    assign qp_sel   = s_req_loc_qp[24*arb_ch +: 24];
    assign immd_sel = s_req_immediate_data[32*arb_ch +: 32];

    // Next descriptor: fresh request from IDLE, or the following segment from DATA.
    always_comb begin
        ld_pm   = (state == IDLE) ? pm_bytes(pmtu) : pm_q;
        ld_rem  = (state == IDLE) ? len_sel  : rem - {19'd0, pm_q};
        ld_addr = (state == IDLE) ? addr_sel : cur_addr + {51'd0, pm_q};
        ld_last = (ld_rem <= {19'd0, ld_pm});
        ld_len  = ld_last ? ld_rem[12:0] : ld_pm;
    end

    assign seg_beats = ({1'b0, m_seg_length} + 14'(KEEP_W - 1)) >> KEEP_SH;
    assign seg_final = (beat_cnt == seg_beats - 14'd1);
    assign in_valid  = s_axis_tvalid[grant];
    assign in_last   = s_axis_tlast[grant];
    assign early     = in_last & ~(seg_final & m_seg_last);

    always_comb begin
        state_nx      = state;
        s_req_ready   = '0;
        s_axis_tready = '0;
        m_seg_valid   = 1'b0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        m_axis_tuser  = 1'b0;
        m_axis_tdata  = s_axis_tdata[DATA_WIDTH*grant +: DATA_WIDTH];
        m_axis_tkeep  = s_axis_tkeep[KEEP_W*grant +: KEEP_W];
        load_first    = 1'b0;
        load_next     = 1'b0;
        beat_hs       = 1'b0;
        case (state)
            IDLE: begin
                if (arb_any && rst_n) begin
                    s_req_ready[arb_ch] = 1'b1;
                    load_first          = 1'b1;
                    state_nx            = DESC;
                end
            end
            DESC: begin
                m_seg_valid = 1'b1;
                if (m_seg_ready) state_nx = (m_seg_length == 13'd0) ? IDLE : DATA;
            end
            DATA: begin
                s_axis_tready[grant] = m_axis_tready;
                m_axis_tvalid        = in_valid;
                m_axis_tlast         = seg_final | in_last;
                m_axis_tuser         = early | (seg_final & m_seg_last & ~in_last);
                beat_hs              = in_valid & m_axis_tready;
                if (beat_hs) begin
                    if (early) begin
                        state_nx = IDLE;
                    end else if (seg_final) begin
                        if (m_seg_last) begin
                            state_nx = in_last ? IDLE : DRAIN;
                        end else begin
                            load_next = 1'b1;
                            state_nx  = DESC;
                        end
                    end
                end
            end
            DRAIN: begin
                s_axis_tready[grant] = 1'b1;
                if (in_valid && in_last) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state                <= IDLE;
            ptr                  <= '0;
            grant                <= '0;
            pm_q                 <= '0;
            rem                  <= '0;
            cur_addr             <= '0;
            is_imm_q             <= 1'b0;
            beat_cnt             <= '0;
            m_seg_ch             <= '0;
            m_seg_loc_qp         <= '0;
            m_seg_addr           <= '0;
            m_seg_length         <= '0;
            m_seg_first          <= 1'b0;
            m_seg_last           <= 1'b0;
            m_seg_is_immediate   <= 1'b0;
            m_seg_immediate_data <= '0;
            m_seg_tx_type        <= 1'b0;
        end else begin
            state <= state_nx;
            if (load_first) begin
                ptr                  <= arb_ch;
                grant                <= arb_ch;
                pm_q                 <= ld_pm;
                is_imm_q             <= s_req_is_immediate[arb_ch];
                m_seg_ch             <= arb_ch;
                m_seg_loc_qp         <= qp_sel;
                m_seg_immediate_data <= immd_sel;
                m_seg_tx_type        <= s_req_tx_type[arb_ch];
                m_seg_first          <= 1'b1;
            end
            if (load_next) m_seg_first <= 1'b0;
            if (load_first || load_next) begin
                rem                <= ld_rem;
                cur_addr           <= ld_addr;
                m_seg_addr         <= ld_addr;
                m_seg_length       <= ld_len;
                m_seg_last         <= ld_last;
                m_seg_is_immediate <= (load_first ? s_req_is_immediate[arb_ch] : is_imm_q) & ld_last;
            end
            if (state == DESC) beat_cnt <= '0;
            else if (beat_hs) beat_cnt <= beat_cnt + 14'd1;
        end
    end
endmodule

// File: tb/tb_axis_multi_ch_segmenter.sv
// Scoreboard bench for axis_multi_ch_segmenter: per-channel source queues feed the DUT,
// expected descriptors/beats are queued by the tests and popped by a negedge monitor.
module tb_axis_multi_ch_segmenter;
    localparam int DW = 512;
    localparam int NC = 4;
    localparam int KW = DW / 8;
    localparam int CW = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NC-1:0]    s_req_valid = '0;
    logic [NC-1:0]    s_req_ready;
    logic [NC*24-1:0] s_req_loc_qp = '0;
    logic [NC*32-1:0] s_req_dma_length = '0;
    logic [NC*64-1:0] s_req_addr_offset = '0;
    logic [NC-1:0]    s_req_is_immediate = '0;
    logic [NC*32-1:0] s_req_immediate_data = '0;
    logic [NC-1:0]    s_req_tx_type = '0;
    logic [NC*DW-1:0] s_axis_tdata = '0;
    logic [NC*KW-1:0] s_axis_tkeep = '0;
    logic [NC-1:0]    s_axis_tvalid = '0;
    logic [NC-1:0]    s_axis_tready;
    logic [NC-1:0]    s_axis_tlast = '0;
    logic             m_seg_valid;
    logic             m_seg_ready = 1'b1;
    logic [CW-1:0]    m_seg_ch;
    logic [23:0]      m_seg_loc_qp;
    logic [63:0]      m_seg_addr;
    logic [12:0]      m_seg_length;
    logic             m_seg_first, m_seg_last, m_seg_is_immediate, m_seg_tx_type;
    logic [31:0]      m_seg_immediate_data;
    logic [DW-1:0]    m_axis_tdata;
    logic [KW-1:0]    m_axis_tkeep;
    logic             m_axis_tvalid;
    logic             m_axis_tready = 1'b1;
    logic             m_axis_tlast, m_axis_tuser;
    logic [2:0]       pmtu = 3'd0;

    axis_multi_ch_segmenter #(.DATA_WIDTH(DW), .NUM_CH(NC)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_req_valid(s_req_valid), .s_req_ready(s_req_ready),
        .s_req_loc_qp(s_req_loc_qp), .s_req_dma_length(s_req_dma_length),
        .s_req_addr_offset(s_req_addr_offset), .s_req_is_immediate(s_req_is_immediate),
        .s_req_immediate_data(s_req_immediate_data), .s_req_tx_type(s_req_tx_type),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
        .m_seg_valid(m_seg_valid), .m_seg_ready(m_seg_ready), .m_seg_ch(m_seg_ch),
        .m_seg_loc_qp(m_seg_loc_qp), .m_seg_addr(m_seg_addr), .m_seg_length(m_seg_length),
        .m_seg_first(m_seg_first), .m_seg_last(m_seg_last),
        .m_seg_is_immediate(m_seg_is_immediate), .m_seg_immediate_data(m_seg_immediate_data),
        .m_seg_tx_type(m_seg_tx_type),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
        .pmtu(pmtu)
    );

    typedef struct { logic [23:0] qp; logic [31:0] len; logic [63:0] addr; logic imm; logic [31:0] immd; logic tx; } req_t;
    typedef struct { logic [DW-1:0] data; logic [KW-1:0] keep; logic last; } beat_t;
    typedef struct { logic [CW-1:0] ch; logic [23:0] qp; logic [63:0] addr; logic [12:0] len;
                     logic first; logic last; logic imm; logic [31:0] immd; logic tx; } desc_t;
    typedef struct { logic [DW-1:0] data; logic [KW-1:0] keep; logic last; logic user; } obeat_t;

    req_t   reqq[NC][$];
    beat_t  bq[NC][$];
    desc_t  exp_d[$];
    obeat_t exp_b[$];
    int     checks = 0;
    int     errors = 0;
    bit     rand_rdy = 1'b0;
    logic [NC-1:0] rf, af;

    function automatic logic [DW-1:0] mk(input int tag);
        logic [31:0] t;
        t = tag;
        return {(DW/32){t}};
    endfunction

    // Source driver: record handshakes at negedge, retire them and present the next heads after posedge.
    always begin
        @(negedge clk);
        rf = s_req_valid & s_req_ready;
        af = s_axis_tvalid & s_axis_tready;
        @(posedge clk);
        #1;
        for (int c = 0; c < NC; c++) begin
            if (rf[c] && reqq[c].size() > 0) reqq[c].delete(0);
            if (af[c] && bq[c].size() > 0) bq[c].delete(0);
            s_req_valid[c] = (reqq[c].size() > 0);
            if (reqq[c].size() > 0) begin
                s_req_loc_qp[24*c +: 24]         = reqq[c][0].qp;
                s_req_dma_length[32*c +: 32]     = reqq[c][0].len;
                s_req_addr_offset[64*c +: 64]    = reqq[c][0].addr;
                s_req_is_immediate[c]            = reqq[c][0].imm;
                s_req_immediate_data[32*c +: 32] = reqq[c][0].immd;
                s_req_tx_type[c]                 = reqq[c][0].tx;
            end
            s_axis_tvalid[c] = (bq[c].size() > 0);
            if (bq[c].size() > 0) begin
                s_axis_tdata[DW*c +: DW] = bq[c][0].data;
                s_axis_tkeep[KW*c +: KW] = bq[c][0].keep;
                s_axis_tlast[c]          = bq[c][0].last;
            end else begin
                s_axis_tlast[c] = 1'b0;
            end
        end
        m_seg_ready   = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        m_axis_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    always @(negedge clk) begin
        desc_t  d;
        obeat_t b;
        if (rst_n) begin
            if (m_seg_valid && m_seg_ready) begin
                checks++;
                if (exp_d.size() == 0) begin
                    errors++;
                    $display("FAIL desc_unexpected: got ch=%0d len=%0d addr=%h, required no descriptor",
                             m_seg_ch, m_seg_length, m_seg_addr);
                end else begin
                    d = exp_d.pop_front();
                    if (m_seg_ch !== d.ch || m_seg_loc_qp !== d.qp || m_seg_addr !== d.addr ||
                        m_seg_length !== d.len || m_seg_first !== d.first || m_seg_last !== d.last ||
                        m_seg_is_immediate !== d.imm || m_seg_immediate_data !== d.immd || m_seg_tx_type !== d.tx) begin
                        errors++;
                        $display("FAIL desc: got ch=%0d qp=%h addr=%h len=%0d first=%b last=%b imm=%b immd=%h tx=%b, required ch=%0d qp=%h addr=%h len=%0d first=%b last=%b imm=%b immd=%h tx=%b",
                                 m_seg_ch, m_seg_loc_qp, m_seg_addr, m_seg_length, m_seg_first, m_seg_last,
                                 m_seg_is_immediate, m_seg_immediate_data, m_seg_tx_type,
                                 d.ch, d.qp, d.addr, d.len, d.first, d.last, d.imm, d.immd, d.tx);
                    end
                end
            end
            if (m_axis_tvalid && m_axis_tready) begin
                checks++;
                if (exp_b.size() == 0) begin
                    errors++;
                    $display("FAIL beat_unexpected: got data=%h last=%b user=%b, required no beat",
                             m_axis_tdata[31:0], m_axis_tlast, m_axis_tuser);
                end else begin
                    b = exp_b.pop_front();
                    if (m_axis_tdata !== b.data || m_axis_tkeep !== b.keep ||
                        m_axis_tlast !== b.last || m_axis_tuser !== b.user) begin
                        errors++;
                        $display("FAIL beat: got data=%h keep=%h last=%b user=%b, required data=%h keep=%h last=%b user=%b",
                                 m_axis_tdata[31:0], m_axis_tkeep, m_axis_tlast, m_axis_tuser,
                                 b.data[31:0], b.keep, b.last, b.user);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, got, want);
        end
    endtask

    task automatic push_req(input int c, input logic [23:0] qp, input logic [31:0] len, input logic [63:0] addr,
                            input logic imm, input logic [31:0] immd, input logic tx);
        req_t r;
        r.qp = qp; r.len = len; r.addr = addr; r.imm = imm; r.immd = immd; r.tx = tx;
        reqq[c].push_back(r);
    endtask

    task automatic push_stream(input int c, input int n, input int tag, input logic [KW-1:0] lastkeep);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.data = mk(tag + i);
            b.keep = (i == n - 1) ? lastkeep : '1;
            b.last = (i == n - 1);
            bq[c].push_back(b);
        end
    endtask

    task automatic exp_desc(input int c, input logic [23:0] qp, input logic [63:0] addr, input logic [12:0] len,
                            input logic first, input logic last, input logic imm, input logic [31:0] immd, input logic tx);
        desc_t d;
        d.ch = CW'(c); d.qp = qp; d.addr = addr; d.len = len; d.first = first; d.last = last;
        d.imm = imm; d.immd = immd; d.tx = tx;
        exp_d.push_back(d);
    endtask

    task automatic exp_beat(input int tag, input logic [KW-1:0] keep, input logic last, input logic user);
        obeat_t b;
        b.data = mk(tag); b.keep = keep; b.last = last; b.user = user;
        exp_b.push_back(b);
    endtask

    function automatic int pending(input int skip_ch);
        int s;
        s = exp_d.size() + exp_b.size();
        for (int c = 0; c < NC; c++) begin
            s += reqq[c].size();
            if (c != skip_ch) s += bq[c].size();
        end
        return s;
    endfunction

    task automatic wait_done(input string name, input int budget, input int skip_ch);
        int n;
        n = 0;
        while (pending(skip_ch) != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (pending(skip_ch) != 0) begin
            errors++;
            $display("FAIL %s_timeout: pending desc=%0d beats=%0d items=%0d, required 0",
                     name, exp_d.size(), exp_b.size(), pending(skip_ch));
        end
        repeat (3) @(posedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1);
    end

    initial begin
        int n;
        logic [63:0] a;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_seg_valid", {63'd0, m_seg_valid}, 64'd0);
        check("rst_axis_tvalid", {63'd0, m_axis_tvalid}, 64'd0);
        check("rst_req_ready", {60'd0, s_req_ready}, 64'd0);
        check("rst_axis_tready", {60'd0, s_axis_tready}, 64'd0);
        check("rst_seg_length", {51'd0, m_seg_length}, 64'd0);
        check("rst_seg_addr", m_seg_addr, 64'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // 600 bytes at PMTU 256: 3 segments, 4/4/2 beats, address carries past bit 15.
        pmtu = 3'd0;
        a = 64'h1000_0000_0000_FF00;
        push_req(0, 24'h123456, 32'd600, a, 1'b1, 32'hCAFE_0001, 1'b1);
        push_stream(0, 10, 32'h100, {40'd0, 24'hFF_FFFF});
        exp_desc(0, 24'h123456, a,           13'd256, 1'b1, 1'b0, 1'b0, 32'hCAFE_0001, 1'b1);
        exp_desc(0, 24'h123456, a + 64'd256, 13'd256, 1'b0, 1'b0, 1'b0, 32'hCAFE_0001, 1'b1);
        exp_desc(0, 24'h123456, a + 64'd512, 13'd88,  1'b0, 1'b1, 1'b1, 32'hCAFE_0001, 1'b1);
        for (int i = 0; i < 10; i++)
            exp_beat(32'h100 + i, (i == 9) ? {40'd0, 24'hFF_FFFF} : '1, (i == 3 || i == 7 || i == 9), 1'b0);
        wait_done("seg600", 400, -1);

        // All four channels at once with pointer at 0: grant order 1, 2, 3, 0.
        pmtu = 3'd2;
        for (int c = 0; c < NC; c++) begin
            push_req(c, 24'h200 + 24'(c), 32'd128, 64'h2000 * c, 1'b0, 32'(c), c[0]);
            push_stream(c, 2, 32'h200 + 16 * c, '1);
        end
        for (int k = 1; k <= NC; k++) begin
            exp_desc(k % NC, 24'h200 + 24'(k % NC), 64'h2000 * (k % NC), 13'd128, 1'b1, 1'b1, 1'b0, 32'(k % NC), 1'(k % NC));
            exp_beat(32'h200 + 16 * (k % NC), '1, 1'b0, 1'b0);
            exp_beat(32'h200 + 16 * (k % NC) + 1, '1, 1'b1, 1'b0);
        end
        wait_done("rr4", 400, -1);

        // Zero-length immediate: one descriptor, the waiting stream beat stays put.
        push_req(2, 24'h333, 32'd0, 64'hABCD, 1'b1, 32'h1234_5678, 1'b0);
        push_stream(2, 1, 32'h300, '1);
        exp_desc(2, 24'h333, 64'hABCD, 13'd0, 1'b1, 1'b1, 1'b1, 32'h1234_5678, 1'b0);
        wait_done("zero_len", 200, 2);
        check("zero_len_stream_untouched", 64'(bq[2].size()), 64'd1);
        bq[2].delete();
        repeat (3) @(posedge clk);

        // Early tlast on beat 5 of a 1024-byte transfer at PMTU 512.
        pmtu = 3'd1;
        push_req(3, 24'h444, 32'd1024, 64'h4000, 1'b0, 32'd0, 1'b0);
        push_stream(3, 5, 32'h400, '1);
        exp_desc(3, 24'h444, 64'h4000, 13'd512, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
        for (int i = 0; i < 5; i++) exp_beat(32'h400 + i, '1, (i == 4), (i == 4));
        wait_done("early_tlast", 200, -1);
        repeat (5) @(posedge clk);
        check("early_tlast_no_more_desc", {63'd0, m_seg_valid}, 64'd0);

        // Stream longer than the request: beat 4 flagged, beats 5-6 drained, then ch2 is granted.
        pmtu = 3'd0;
        push_req(1, 24'h555, 32'd256, 64'h5000, 1'b0, 32'd0, 1'b0);
        push_stream(1, 6, 32'h500, '1);
        push_req(2, 24'h666, 32'd64, 64'h6000, 1'b0, 32'd7, 1'b1);
        push_stream(2, 1, 32'h600, '1);
        exp_desc(1, 24'h555, 64'h5000, 13'd256, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
        for (int i = 0; i < 4; i++) exp_beat(32'h500 + i, '1, (i == 3), (i == 3));
        exp_desc(2, 24'h666, 64'h6000, 13'd64, 1'b1, 1'b1, 1'b0, 32'd7, 1'b1);
        exp_beat(32'h600, '1, 1'b1, 1'b0);
        wait_done("long_stream", 300, -1);

        // Random backpressure, then reset in the middle of the data phase.
        push_req(0, 24'h777, 32'd1024, 64'h7000, 1'b0, 32'd0, 1'b0);
        push_stream(0, 16, 32'h700, '1);
        for (int s = 0; s < 4; s++) begin
            exp_desc(0, 24'h777, 64'h7000 + 64'd256 * s, 13'd256, (s == 0), (s == 3), 1'b0, 32'd0, 1'b0);
            for (int i = 0; i < 4; i++) exp_beat(32'h700 + 4 * s + i, '1, (i == 3), 1'b0);
        end
        rand_rdy = 1'b1;
        n = 0;
        while (!(exp_b.size() <= 9 && m_axis_tvalid) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("midreset_reached_data", {63'd0, m_axis_tvalid}, 64'd1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midreset_seg_valid", {63'd0, m_seg_valid}, 64'd0);
        check("midreset_axis_tvalid", {63'd0, m_axis_tvalid}, 64'd0);
        check("midreset_axis_tready", {60'd0, s_axis_tready}, 64'd0);
        check("midreset_req_ready", {60'd0, s_req_ready}, 64'd0);
        check("midreset_seg_length", {51'd0, m_seg_length}, 64'd0);
        for (int c = 0; c < NC; c++) begin
            reqq[c].delete();
            bq[c].delete();
        end
        exp_d.delete();
        exp_b.delete();
        rand_rdy = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        // Pointer back at 0 after reset: ch1 wins over ch0.
        push_req(0, 24'h880, 32'd64, 64'h8000, 1'b0, 32'd0, 1'b0);
        push_req(1, 24'h881, 32'd64, 64'h8100, 1'b0, 32'd0, 1'b0);
        push_stream(0, 1, 32'h800, '1);
        push_stream(1, 1, 32'h810, '1);
        exp_desc(1, 24'h881, 64'h8100, 13'd64, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
        exp_beat(32'h810, '1, 1'b1, 1'b0);
        exp_desc(0, 24'h880, 64'h8000, 13'd64, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
        exp_beat(32'h800, '1, 1'b1, 1'b0);
        wait_done("post_reset_rr", 200, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
